// File: rtl/mem_if_pkg.sv
// Shared types for the cache line memory interface.
// Line width, address width, responder states and op codes.
package mem_if_pkg;

   localparam int LINE_W     = 128;
   localparam int MEM_ADDR_W = 28;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE,
      GAP
   } state_t;

   typedef enum logic {
      OP_RD,
      OP_WR
   } op_t;

endpackage

// File: rtl/mem_line_array.sv
// Single-port line store with a registered read port.
// Contents are never cleared; rdata lags idx by one cycle.
module mem_line_array
   import mem_if_pkg::*;
#(
   parameter int DEPTH_BITS = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_BITS-1:0] idx,
   input  logic [LINE_W-1:0]     wdata,
   output logic [LINE_W-1:0]     rdata
);

   logic [LINE_W-1:0] r_mem [2**DEPTH_BITS];
   logic [LINE_W-1:0] r_rdata;

   // write on we, read every cycle into the output register
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[idx] <= wdata;
      end
      r_rdata <= r_mem[idx];
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/mem_line_responder.sv
// Slow-memory responder: one line request at a time, fixed latency,
// one-cycle ready pulse, sticky flag for cache handshake violations.
module mem_line_responder
   import mem_if_pkg::*;
#(
   parameter int LATENCY    = 7,
   parameter int DEPTH_BITS = 10
) (
   input  logic                  clk,
   input  logic                  proc_reset_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [MEM_ADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0]     mem_wdata,
   output logic                  mem_ready,
   output logic [LINE_W-1:0]     mem_rdata,
   output logic                  protocol_err
);

   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t                r_state;
   state_t                w_next;
   logic [CW-1:0]         r_cnt;
   op_t                   r_op;
   logic                  r_rd;
   logic                  r_wr;
   logic [MEM_ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0]     r_wdata;
   logic                  r_ready;
   logic                  r_err;

   logic                  w_req;
   logic                  w_accept;
   logic                  w_mismatch;
   logic                  w_we;
   logic [DEPTH_BITS-1:0] w_idx;
   logic [LINE_W-1:0]     w_arr_rdata;

   assign w_req    = mem_read | mem_write;
   assign w_accept = (r_state == IDLE) & w_req;

   assign w_mismatch = (mem_read != r_rd)
                     | (mem_write != r_wr)
                     | (mem_addr != r_addr);

   // LATENCY=1 reads the array straight from the live address in IDLE
   assign w_idx = (r_state == IDLE) ? mem_addr[DEPTH_BITS-1:0]
                                    : r_addr[DEPTH_BITS-1:0];

   // a write lands only if its DONE cycle ends with reset released
   assign w_we = (r_state == DONE) & (r_op == OP_WR) & proc_reset_n;

   // next-state selection
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_req) begin
               w_next = (LATENCY == 1) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (r_cnt == CNT_ONE) begin
               w_next = DONE;
            end
         end
         DONE:    w_next = GAP;
         GAP:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!proc_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // latency counter: loaded on accept, counts down through BUSY
   always_ff @(posedge clk) begin
      if (!proc_reset_n) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= CNT_INIT;
      end else if (r_state == BUSY) begin
         r_cnt <= r_cnt - CNT_ONE;
      end
   end

   // capture the request as seen on the accepting edge
   always_ff @(posedge clk) begin
      if (!proc_reset_n) begin
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_op    <= OP_RD;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_rd    <= mem_read;
         r_wr    <= mem_write;
         r_op    <= mem_write ? OP_WR : OP_RD;
         r_addr  <= mem_addr;
         r_wdata <= mem_wdata;
      end
   end

   // registered ready pulse and sticky handshake checker
   always_ff @(posedge clk) begin
      if (!proc_reset_n) begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ready <= (w_next == DONE);
         if (w_accept && mem_read && mem_write) begin
            r_err <= 1'b1;
         end
         if ((r_state == BUSY) && w_mismatch) begin
            r_err <= 1'b1;
         end
      end
   end

   mem_line_array #(
      .DEPTH_BITS(DEPTH_BITS)
   ) u_array (
      .clk  (clk),
      .we   (w_we),
      .idx  (w_idx),
      .wdata(r_wdata),
      .rdata(w_arr_rdata)
   );

   assign mem_ready    = r_ready;
   assign mem_rdata    = r_ready ? w_arr_rdata : '0;
   assign protocol_err = r_err;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: LATENCY=7 and LATENCY=1
// instances, vector table plus hand sequences for abort and errors.
module tb_mem_line_responder;

   localparam logic [127:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] DA = 128'hAAAA5555AAAA5555AAAA5555AAAA5555;
   localparam logic [127:0] DB = 128'hBBBB0000BBBB0000BBBB0000BBBB0000;
   localparam logic [127:0] DC = 128'hC0C0C0C0C0C0C0C0C0C0C0C0C0C0C0C0;
   localparam logic [127:0] DD = 128'hDDDD1111DDDD1111DDDD1111DDDD1111;
   localparam logic [127:0] DE = 128'hEEEE2222EEEE2222EEEE2222EEEE2222;

   typedef struct {
      int           s;
      bit           rd;
      bit           wr;
      logic [27:0]  a;
      logic [127:0] wd;
      logic [127:0] exp_rd;
      int           exp_lat;
      bit           exp_err;
      bit           b2b;
      string        nm;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         rd    [2];
   logic         wr    [2];
   logic [27:0]  addr  [2];
   logic [127:0] wdata [2];
   logic         rdy   [2];
   logic [127:0] rdat  [2];
   logic         perr  [2];

   int  n_vec = 0;
   int  n_bad = 0;
   vec_t tv [11];

   always #5 clk = ~clk;

   mem_line_responder #(
      .LATENCY(7),
      .DEPTH_BITS(10)
   ) dut7 (
      .clk         (clk),
      .proc_reset_n(rst_n),
      .mem_read    (rd[0]),
      .mem_write   (wr[0]),
      .mem_addr    (addr[0]),
      .mem_wdata   (wdata[0]),
      .mem_ready   (rdy[0]),
      .mem_rdata   (rdat[0]),
      .protocol_err(perr[0])
   );

   mem_line_responder #(
      .LATENCY(1),
      .DEPTH_BITS(10)
   ) dut1 (
      .clk         (clk),
      .proc_reset_n(rst_n),
      .mem_read    (rd[1]),
      .mem_write   (wr[1]),
      .mem_addr    (addr[1]),
      .mem_wdata   (wdata[1]),
      .mem_ready   (rdy[1]),
      .mem_rdata   (rdat[1]),
      .protocol_err(perr[1])
   );

   task automatic chk(input string nm,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // one request, held until ready, dropped in the ready cycle
   task automatic txn(input int s, input bit r, input bit w,
                      input logic [27:0] a, input logic [127:0] wd,
                      output logic [127:0] rdv, output int lat,
                      output bit idle_bad, output bit gap_bad,
                      output longint t_rdy);
      @(negedge clk);
      rd[s]    = r;
      wr[s]    = w;
      addr[s]  = a;
      wdata[s] = wd;
      lat      = 0;
      idle_bad = 1'b0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (rdy[s] === 1'b1) break;
         if (rdat[s] !== '0) idle_bad = 1'b1;
      end
      rdv   = rdat[s];
      t_rdy = longint'($time);
      rd[s] = 1'b0;
      wr[s] = 1'b0;
      @(negedge clk);
      gap_bad = (rdy[s] !== 1'b0) || (rdat[s] !== '0);
   endtask

   initial begin
      logic [127:0] rdv;
      int           lat;
      int           n;
      bit           ib;
      bit           gb;
      bit           seen;
      longint       t;
      longint       prev_t [2];

      tv[0]  = '{0, 0, 1, 28'h10,  D0, 0,  7, 0, 0, "wr10"};
      tv[1]  = '{0, 1, 0, 28'h10,  0,  D0, 7, 0, 0, "rd10"};
      tv[2]  = '{0, 1, 0, 28'h10,  0,  D0, 7, 0, 1, "rd10_b2b"};
      tv[3]  = '{0, 0, 1, 28'h30,  DA, 0,  7, 0, 0, "wr30"};
      tv[4]  = '{0, 0, 1, 28'h20,  DE, 0,  7, 0, 0, "wr20"};
      tv[5]  = '{0, 1, 0, 28'h20,  0,  DE, 7, 0, 1, "rd20_b2b"};
      tv[6]  = '{0, 1, 0, 28'h30,  0,  DA, 7, 0, 1, "rd30_b2b"};
      tv[7]  = '{1, 1, 1, 28'h40,  DC, 0,  1, 1, 0, "l1_both40"};
      tv[8]  = '{1, 1, 0, 28'h40,  0,  DC, 1, 1, 1, "l1_rd40"};
      tv[9]  = '{1, 0, 1, 28'h400, DD, 0,  1, 1, 0, "l1_wr400"};
      tv[10] = '{1, 1, 0, 28'h0,   0,  DD, 1, 1, 1, "l1_rd000"};

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd[i]    = 1'b0;
         wr[i]    = 1'b0;
         addr[i]  = '0;
         wdata[i] = '0;
         prev_t[i] = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_ready", 128'(rdy[i]), 128'd0);
         chk("rst_rdata", rdat[i], 128'd0);
         chk("rst_err", 128'(perr[i]), 128'd0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         txn(tv[i].s, tv[i].rd, tv[i].wr, tv[i].a, tv[i].wd,
             rdv, lat, ib, gb, t);
         chk({tv[i].nm, "_lat"}, 128'(lat), 128'(tv[i].exp_lat));
         chk({tv[i].nm, "_err"}, 128'(perr[tv[i].s]),
             128'(tv[i].exp_err));
         chk({tv[i].nm, "_idle0"}, 128'(ib), 128'd0);
         chk({tv[i].nm, "_gap0"}, 128'(gb), 128'd0);
         if (tv[i].rd && !tv[i].wr) begin
            chk({tv[i].nm, "_data"}, rdv, tv[i].exp_rd);
         end
         if (tv[i].b2b) begin
            chk({tv[i].nm, "_spacing"}, 128'((t - prev_t[tv[i].s]) / 10),
                128'(tv[i].exp_lat + 2));
         end
         prev_t[tv[i].s] = t;
      end

      // address changes in the 3rd BUSY cycle
      @(negedge clk);
      rd[0]   = 1'b1;
      addr[0] = 28'h10;
      n = 0;
      repeat (3) begin
         @(negedge clk);
         n++;
      end
      addr[0] = 28'h20;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (rdy[0] === 1'b1) break;
      end
      chk("chg_lat", 128'(n), 128'd7);
      chk("chg_data", rdat[0], D0);
      chk("chg_err", 128'(perr[0]), 128'd1);
      rd[0] = 1'b0;
      repeat (5) @(negedge clk);
      chk("chg_err_sticky", 128'(perr[0]), 128'd1);

      // reset during BUSY of a write to 0x30 must abort it
      @(negedge clk);
      wr[0]    = 1'b1;
      addr[0]  = 28'h30;
      wdata[0] = DB;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      wr[0] = 1'b0;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (rdy[0] !== 1'b0) seen = 1'b1;
      end
      chk("abort_no_ready", 128'(seen), 128'd0);
      chk("abort_err_clr", 128'(perr[0]), 128'd0);
      txn(0, 1'b1, 1'b0, 28'h30, '0, rdv, lat, ib, gb, t);
      chk("abort_rd30_lat", 128'(lat), 128'd7);
      chk("abort_rd30_data", rdv, DA);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
